soc_bus_arbiter: RTL and testbench
==================================

# soc_bus_arbiter

Parametrised N-domain bus arbiter between the CPU domains and the single `busctl` bus unit in `soc`. It replaces the fixed one-domain, tied-off bus hookup. Each domain raises a request carrying a read or write. A round-robin FSM grants one request at a time, drives it onto the `busctl` port for one cycle, and returns the read data and a one-cycle acknowledge to the winning domain. A free-running transfer counter is exposed for debug.

## Interface
Parameters:
- `N_DOMAINS`, default 2: number of requesting domains, ≥1.
- `ADDR_WIDTH`, default 8: bus address width.
- `DATA_WIDTH`, default 8: bus data width.
- `CNT_WIDTH`, default 16: width of the transfer counter.

Ports:
- `clk`  in  1  sole clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  N_DOMAINS  per-domain request; held high until the matching `ack`.
- `we`  in  N_DOMAINS  per-domain write enable (1 = write, 0 = read).
- `addr`  in  N_DOMAINS*ADDR_WIDTH  domain i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `wdata`  in  N_DOMAINS*DATA_WIDTH  domain i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ack`  out  N_DOMAINS  one-cycle completion pulse, one-hot or zero.
- `rdata`  out  DATA_WIDTH  last read result; valid in the `ack` cycle of a read.
- `busy`  out  1  high while a transaction is in ISSUE or RESP.
- `xfer_count`  out  CNT_WIDTH  completed transactions, wraps.
- `bus_write_en`  out  1  to busctl `write_en`.
- `bus_addr`  out  ADDR_WIDTH  to busctl `addr_in`.
- `bus_wdata`  out  DATA_WIDTH  to busctl `data_in`.
- `bus_rdata`  in  DATA_WIDTH  from busctl `data_out`; registered inside busctl.

## Operation
- The FSM has three states: IDLE → ISSUE → RESP → IDLE. The reset state is IDLE.
- **IDLE arbitration**
  - Eligible set = `req` with the bit of any domain whose `ack` is high this cycle masked off.
  - If the eligible set is non-empty, the winner is the first eligible index scanning ptr, ptr+1, … with wrap mod N_DOMAINS.
  - On the transition edge, register the winner index, `we`, `addr` slice and `wdata` slice, then go to ISSUE.
  - Set ptr ← (winner+1) mod N_DOMAINS.
  - If the eligible set is empty, stay in IDLE.
- **ISSUE**
  - `bus_write_en` = latched we; `bus_addr`/`bus_wdata` = latched values.
  - Lasts exactly one cycle, then RESP.
- **RESP**
  - `bus_write_en` = 0; `bus_rdata` now reflects the ISSUE address.
  - On exit edge:
    - If the latched we is 0, `rdata` ← `bus_rdata`; `rdata` is unchanged on writes.
    - `ack[winner]` ← 1 for exactly one cycle.
    - `xfer_count` ← `xfer_count`+1, mod 2^CNT_WIDTH.
  - Then IDLE.
- `bus_addr` and `bus_wdata` hold their last latched values outside ISSUE.
- `bus_write_en` is 0 in every state except ISSUE with we=1.
- Inputs are sampled only at the IDLE→ISSUE edge. Later changes to req/we/addr/wdata, including dropping req, do not affect the transaction in flight. It still completes and acks.
- With N_DOMAINS=1, ptr is constantly 0 and the arbitration is trivial.

## Timing
- Reset (synchronous): next edge sets state IDLE, ptr 0, `ack` 0, `rdata` 0, `busy` 0, `xfer_count` 0, `bus_write_en` 0, `bus_addr` 0, `bus_wdata` 0.
- Reset mid-transaction abandons it: no ack, no counter increment, no `rdata` update.
- Latency from the first cycle req is seen in IDLE to the `ack` cycle: 3 cycles.
  - Cycle 0: IDLE, sample.
  - Cycle 1: ISSUE.
  - Cycle 2: RESP.
  - Cycle 3: ack.
- Peak throughput is one transaction per 3 cycles. The `ack` cycle is the next IDLE cycle, so the following arbitration overlaps it.
- `busy` = (state ≠ IDLE), registered with the state.
- The acked domain cannot win in its own `ack` cycle. With all domains requesting continuously, grant order is 0,1,…,N-1,0,…
- Simultaneous requests are resolved by ptr only; there is no fixed priority.

## Test plan
- **Reset:** assert `reset` for 2 cycles mid-ISSUE of a write → all outputs 0 next cycle, no `ack`, `xfer_count`=0, FSM IDLE.
- **Single read:** N=2, busctl preloaded mem[0x10]=0xA5; domain 0 req, we=0, addr=0x10 → `bus_addr`=0x10 in ISSUE, `ack`=2'b01 exactly 3 cycles after sample, `rdata`=0xA5, `xfer_count`=1.
- **Write then read-back:** domain 1 writes 0x3C to 0x20, then reads 0x20 → `bus_write_en`=1 only in the write's ISSUE cycle, read returns 0x3C, `rdata` unchanged (0) after the write's ack.
- **Round-robin fairness:** N=4, all req held high for 24 cycles → acks in order 0,1,2,3,0,1,2,3, each exactly 3 cycles apart, `xfer_count`=8.
- **Req drop mid-flight:** domain 0 drops req during ISSUE → ack still pulses for domain 0 in cycle 3, no second grant to domain 0.
- **Counter wrap:** CNT_WIDTH=2, 5 transactions → `xfer_count` sequence 1,2,3,0,1.

Source files
------------

// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter: round-robin arbiter that funnels N CPU-domain requests
// onto the single busctl port, one transaction at a time, and returns the
// read data plus a one-cycle ack to the winning domain.

// Per-domain slice: eligibility masking and grant decode for one domain.
module soc_bus_arbiter_lane #(
    parameter int PTR_W = 1,
    parameter int LANE  = 0
) (
    input  logic             req,
    input  logic             ack,
    input  logic [PTR_W-1:0] sel_idx,
    output logic             elig,
    output logic             hit
);

    // A domain being acked this cycle must not win again in the same cycle.
    assign elig = req & ~ack;
    assign hit  = (sel_idx == PTR_W'(LANE));

endmodule

module soc_bus_arbiter #(
    parameter int N_DOMAINS  = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_DOMAINS-1:0]             req,
    input  logic [N_DOMAINS-1:0]             we,
    input  logic [N_DOMAINS*ADDR_WIDTH-1:0]  addr,
    input  logic [N_DOMAINS*DATA_WIDTH-1:0]  wdata,
    output logic [N_DOMAINS-1:0]             ack,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             busy,
    output logic [CNT_WIDTH-1:0]             xfer_count,
    output logic                             bus_write_en,
    output logic [ADDR_WIDTH-1:0]            bus_addr,
    output logic [DATA_WIDTH-1:0]            bus_wdata,
    input  logic [DATA_WIDTH-1:0]            bus_rdata
);

    // A one-domain build still needs a 1-bit pointer; it simply stays 0.
    localparam int PTR_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Everything captured at the grant edge; the in-flight transaction uses
    // only this copy, so requesters may change or drop their inputs freely.
    typedef struct packed {
        logic [PTR_W-1:0]      idx;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } xfer_t;

    state_t               state;
    logic [PTR_W-1:0]     ptr;
    xfer_t                cur;

    logic [N_DOMAINS-1:0] elig;
    logic [N_DOMAINS-1:0] hit;
    logic                 found;
    logic [PTR_W-1:0]     win;
    logic [PTR_W-1:0]     nxt_ptr;
    logic                 win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    for (genvar i = 0; i < N_DOMAINS; i++) begin : g_lane
        soc_bus_arbiter_lane #(
            .PTR_W (PTR_W),
            .LANE  (i)
        ) u_lane (
            .req     (req[i]),
            .ack     (ack[i]),
            .sel_idx (cur.idx),
            .elig    (elig[i]),
            .hit     (hit[i])
        );
    end

    // Round-robin scan: first eligible domain starting at ptr, wrapping.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_DOMAINS; i++) begin
            j = int'(ptr) + i;
            if (j >= N_DOMAINS) j = j - N_DOMAINS;
            if (!found && elig[j]) begin
                found = 1'b1;
                win   = PTR_W'(j);
            end
        end
    end

    // Winner's request fields and the pointer that follows it.
    always_comb begin
        win_we    = we[win];
        win_addr  = addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata = wdata[win*DATA_WIDTH +: DATA_WIDTH];
        nxt_ptr   = (win == PTR_W'(N_DOMAINS - 1)) ? '0 : win + 1'b1;
    end

    // Transaction FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            cur          <= '0;
            ack          <= '0;
            rdata        <= '0;
            busy         <= 1'b0;
            xfer_count   <= '0;
            bus_write_en <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        cur.idx      <= win;
                        cur.we       <= win_we;
                        cur.addr     <= win_addr;
                        cur.wdata    <= win_wdata;
                        ptr          <= nxt_ptr;
                        // Bus drive lines are loaded now so they are valid
                        // for the whole ISSUE cycle and hold afterwards.
                        bus_write_en <= win_we;
                        bus_addr     <= win_addr;
                        bus_wdata    <= win_wdata;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus_write_en <= 1'b0;
                    state        <= RESP;
                end
                RESP: begin
                    // busctl registers its read port, so data is valid here.
                    if (!cur.we) rdata <= bus_rdata;
                    ack        <= hit;
                    xfer_count <= xfer_count + 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    bus_write_en <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Directed bench for soc_bus_arbiter: a 2-domain instance for reset, read,
// write/read-back and req-drop, a 4-domain instance for round-robin order,
// and a 1-domain 2-bit-counter instance for counter wrap.
module tb_soc_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // instance A: N=2
    logic [1:0]  req_a = '0, we_a = '0, ack_a;
    logic [15:0] addr_a = '0, wdata_a = '0, cnt_a;
    logic [7:0]  rdata_a, baddr_a, bwd_a, brd_a;
    logic        busy_a, bwe_a;
    logic [7:0]  mem_a [256];

    // instance B: N=4
    logic [3:0]  req_b = '0, we_b = '0, ack_b;
    logic [31:0] addr_b = '0, wdata_b = '0;
    logic [15:0] cnt_b;
    logic [7:0]  rdata_b, baddr_b, bwd_b, brd_b;
    logic        busy_b, bwe_b;
    logic [7:0]  mem_b [256];

    // instance C: N=1, CNT_WIDTH=2
    logic [0:0]  req_c = '0, we_c = '0, ack_c;
    logic [7:0]  addr_c = '0, wdata_c = '0;
    logic [1:0]  cnt_c;
    logic [7:0]  rdata_c, baddr_c, bwd_c, brd_c;
    logic        busy_c, bwe_c;
    logic [7:0]  mem_c [256];

    soc_bus_arbiter #(.N_DOMAINS(2), .ADDR_WIDTH(8), .DATA_WIDTH(8), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .ack(ack_a), .rdata(rdata_a), .busy(busy_a), .xfer_count(cnt_a),
        .bus_write_en(bwe_a), .bus_addr(baddr_a), .bus_wdata(bwd_a), .bus_rdata(brd_a));

    soc_bus_arbiter #(.N_DOMAINS(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .ack(ack_b), .rdata(rdata_b), .busy(busy_b), .xfer_count(cnt_b),
        .bus_write_en(bwe_b), .bus_addr(baddr_b), .bus_wdata(bwd_b), .bus_rdata(brd_b));

    soc_bus_arbiter #(.N_DOMAINS(1), .ADDR_WIDTH(8), .DATA_WIDTH(8), .CNT_WIDTH(2)) dut_c (
        .clk(clk), .reset(reset), .req(req_c), .we(we_c), .addr(addr_c), .wdata(wdata_c),
        .ack(ack_c), .rdata(rdata_c), .busy(busy_c), .xfer_count(cnt_c),
        .bus_write_en(bwe_c), .bus_addr(baddr_c), .bus_wdata(bwd_c), .bus_rdata(brd_c));

    // busctl models: synchronous write, registered read
    always @(posedge clk) begin
        if (reset) mem_a[8'h10] <= 8'hA5;
        else if (bwe_a) mem_a[baddr_a] <= bwd_a;
        brd_a <= mem_a[baddr_a];
    end
    always @(posedge clk) begin
        if (bwe_b) mem_b[baddr_b] <= bwd_b;
        brd_b <= mem_b[baddr_b];
    end
    always @(posedge clk) begin
        if (bwe_c) mem_c[baddr_c] <= bwd_c;
        brd_c <= mem_c[baddr_c];
    end

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_a = '0; we_a = '0; req_b = '0; we_b = '0; req_c = '0; we_c = '0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic bad;
        do_reset();
        checks++; if ({ack_a, rdata_a, busy_a, cnt_a, bwe_a, baddr_a, bwd_a} !== '0) begin
            errors++; $display("FAIL reset_outputs: got ack=%b rdata=%h busy=%b cnt=%0d we=%b addr=%h wd=%h, want all 0",
                ack_a, rdata_a, busy_a, cnt_a, bwe_a, baddr_a, bwd_a); end
        // start a write from domain 1, then reset during its ISSUE cycle
        req_a = 2'b10; we_a = 2'b10; addr_a = 16'h3000; wdata_a = 16'h5A00;
        cyc();
        checks++; if ({busy_a, bwe_a, baddr_a} !== {1'b1, 1'b1, 8'h30}) begin
            errors++; $display("FAIL reset_issue: got busy=%b we=%b addr=%h want 1 1 30", busy_a, bwe_a, baddr_a); end
        reset = 1'b1; req_a = '0; we_a = '0;
        cyc();
        checks++; if ({ack_a, rdata_a, busy_a, cnt_a, bwe_a, baddr_a, bwd_a} !== '0) begin
            errors++; $display("FAIL reset_mid_txn: got ack=%b rdata=%h busy=%b cnt=%0d we=%b addr=%h wd=%h, want all 0",
                ack_a, rdata_a, busy_a, cnt_a, bwe_a, baddr_a, bwd_a); end
        cyc();
        reset = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (ack_a !== 2'b00 || busy_a !== 1'b0 || cnt_a !== 16'd0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin
            errors++; $display("FAIL reset_abandon: got ack=%b busy=%b cnt=%0d after reset, want 0 0 0", ack_a, busy_a, cnt_a); end
    endtask

    task automatic test_single_read;
        do_reset();
        req_a = 2'b01; we_a = 2'b00; addr_a = 16'h0010;
        cyc();
        checks++; if ({busy_a, bwe_a, baddr_a, ack_a} !== {1'b1, 1'b0, 8'h10, 2'b00}) begin
            errors++; $display("FAIL read_issue: got busy=%b we=%b addr=%h ack=%b want 1 0 10 00", busy_a, bwe_a, baddr_a, ack_a); end
        cyc();
        checks++; if (ack_a !== 2'b00) begin
            errors++; $display("FAIL read_early_ack: got %b want 00", ack_a); end
        cyc();
        checks++; if ({ack_a, rdata_a, cnt_a} !== {2'b01, 8'hA5, 16'd1}) begin
            errors++; $display("FAIL read_ack: got ack=%b rdata=%h cnt=%0d want 01 a5 1", ack_a, rdata_a, cnt_a); end
        req_a = 2'b00;
        cyc();
        checks++; if ({ack_a, busy_a} !== 3'b000) begin
            errors++; $display("FAIL read_after: got ack=%b busy=%b want 00 0", ack_a, busy_a); end
    endtask

    task automatic test_write_readback;
        do_reset();
        req_a = 2'b10; we_a = 2'b10; addr_a = 16'h2000; wdata_a = 16'h3C00;
        cyc();
        checks++; if ({bwe_a, baddr_a, bwd_a} !== {1'b1, 8'h20, 8'h3C}) begin
            errors++; $display("FAIL wr_issue: got we=%b addr=%h wd=%h want 1 20 3c", bwe_a, baddr_a, bwd_a); end
        cyc();
        checks++; if (bwe_a !== 1'b0) begin
            errors++; $display("FAIL wr_resp_we: got %b want 0", bwe_a); end
        cyc();
        checks++; if ({ack_a, rdata_a, bwe_a} !== {2'b10, 8'h00, 1'b0}) begin
            errors++; $display("FAIL wr_ack: got ack=%b rdata=%h we=%b want 10 00 0", ack_a, rdata_a, bwe_a); end
        req_a = 2'b00; we_a = 2'b00;
        cyc();
        req_a = 2'b10;
        cyc();
        checks++; if ({bwe_a, baddr_a} !== {1'b0, 8'h20}) begin
            errors++; $display("FAIL rd_issue: got we=%b addr=%h want 0 20", bwe_a, baddr_a); end
        cyc();
        cyc();
        checks++; if ({ack_a, rdata_a, cnt_a} !== {2'b10, 8'h3C, 16'd2}) begin
            errors++; $display("FAIL readback: got ack=%b rdata=%h cnt=%0d want 10 3c 2", ack_a, rdata_a, cnt_a); end
        req_a = 2'b00;
        cyc();
    endtask

    task automatic test_req_drop;
        logic bad;
        do_reset();
        req_a = 2'b01; we_a = 2'b00; addr_a = 16'h0010;
        cyc();
        req_a = 2'b00;
        addr_a = 16'h00FF;
        cyc();
        cyc();
        checks++; if ({ack_a, rdata_a} !== {2'b01, 8'hA5}) begin
            errors++; $display("FAIL drop_ack: got ack=%b rdata=%h want 01 a5", ack_a, rdata_a); end
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (ack_a !== 2'b00 || busy_a !== 1'b0) bad = 1'b1;
        end
        checks++; if ({bad, cnt_a} !== {1'b0, 16'd1}) begin
            errors++; $display("FAIL drop_regrant: got extra activity=%b cnt=%0d want 0 1", bad, cnt_a); end
    endtask

    task automatic test_round_robin;
        int exp_dom;
        logic [3:0] expv;
        do_reset();
        req_b = 4'hF; we_b = 4'hF; addr_b = 32'h43424140; wdata_b = 32'h03020100;
        exp_dom = 0;
        for (int k = 1; k <= 24; k++) begin
            cyc();
            if (k % 3 == 0) begin
                expv = 4'b0001 << exp_dom;
                checks++; if (ack_b !== expv) begin
                    errors++; $display("FAIL rr_ack_c%0d: got %b want %b", k, ack_b, expv); end
                exp_dom = (exp_dom + 1) % 4;
            end else begin
                checks++; if (ack_b !== 4'b0000) begin
                    errors++; $display("FAIL rr_idle_c%0d: got %b want 0000", k, ack_b); end
            end
        end
        req_b = 4'h0;
        cyc();
        cyc();
        checks++; if ({cnt_b, busy_b} !== {16'd8, 1'b0}) begin
            errors++; $display("FAIL rr_count: got cnt=%0d busy=%b want 8 0", cnt_b, busy_b); end
    endtask

    task automatic test_counter_wrap;
        logic [1:0] expc;
        int lat;
        do_reset();
        for (int t = 0; t < 5; t++) begin
            req_c = 1'b1; we_c = 1'b1; addr_c = 8'(t); wdata_c = 8'(t + 8'h50);
            lat = 0;
            while (ack_c !== 1'b1 && lat < 8) begin
                cyc();
                lat++;
            end
            expc = 2'(t + 1);
            checks++; if (ack_c !== 1'b1 || lat != 3 || cnt_c !== expc) begin
                errors++; $display("FAIL wrap_t%0d: got ack=%b latency=%0d cnt=%0d want 1 3 %0d", t, ack_c, lat, cnt_c, expc); end
            req_c = 1'b0;
            cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_readback();
        test_req_drop();
        test_round_robin();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
